calendar_date_gen: RTL

//  Date keeper for the watch datapath: holds year/month/day/weekday, advances
//  on a one-cycle day-rollover pulse from the time-of-day block, and edits

---
 rtl/cal_pkg.sv | 31 +++
 rtl/calendar_date_gen_if.sv | 24 ++
 rtl/cal_bcd_split.sv | 9 +
 rtl/calendar_date_gen.sv | 125 ++++++++++++
 4 files changed

// File: rtl/cal_pkg.sv
// Shared constants, date record and month-length helper for the calendar date keeper.
package cal_pkg;

   localparam logic [3:0] OPT_DATE_SET = 4'b0011;

   typedef enum logic [3:0] {
      FIELD_DAY   = 4'b0001,
      FIELD_MONTH = 4'b0010,
      FIELD_YEAR  = 4'b0011,
      FIELD_WDAY  = 4'b0100
   } field_e;

   typedef struct packed {
      logic [6:0] year;
      logic [6:0] month;
      logic [6:0] day;
      logic [2:0] wday;
   } date_t;

   // Year is binary 0..99, so year%4==0 is just the two low bits.
   function automatic logic [4:0] month_len(input logic [6:0] month,
                                            input logic [6:0] year,
                                            input logic       leap_en);
      case (month)
         7'd4, 7'd6, 7'd9, 7'd11: month_len = 5'd30;
         7'd2:    month_len = (leap_en && (year[1:0] == 2'b00)) ? 5'd29 : 5'd28;
         default: month_len = 5'd31;
      endcase
   endfunction

endpackage

// File: rtl/calendar_date_gen_if.sv
// Button/tick inputs and BCD display outputs of the calendar date keeper.
interface calendar_date_gen_if;
   logic       DAY_TICK;
   logic       U;
   logic       D;
   logic [3:0] OPTION;
   logic [3:0] COUNT;
   logic [3:0] y10, y1;
   logic [3:0] m10, m1;
   logic [3:0] d10, d1;
   logic [2:0] WDAY;
   logic       LEAP;
   logic       YEAR_WRAP;

   modport slave (
      input  DAY_TICK, U, D, OPTION, COUNT,
      output y10, y1, m10, m1, d10, d1, WDAY, LEAP, YEAR_WRAP
   );

   modport master (
      output DAY_TICK, U, D, OPTION, COUNT,
      input  y10, y1, m10, m1, d10, d1, WDAY, LEAP, YEAR_WRAP
   );
endinterface

// File: rtl/cal_bcd_split.sv
// Binary 0..99 to two BCD digits.
module cal_bcd_split (
   input  logic [6:0] bin,
   output logic [3:0] tens,
   output logic [3:0] ones
);
   assign tens = 4'(bin / 7'd10);
   assign ones = 4'(bin % 7'd10);
endmodule

// File: rtl/calendar_date_gen.sv
// Date keeper: day-tick carry chain, button edits with day clamp, weekday counter.
module calendar_date_gen
   import cal_pkg::*;
#(
   parameter int YEAR_MIN  = 1,
   parameter int YEAR_MAX  = 99,
   parameter int RST_YEAR  = 20,
   parameter int RST_MONTH = 12,
   parameter int RST_DAY   = 15,
   parameter int RST_WDAY  = 0,
   parameter int LEAP_EN   = 1
) (
   input logic                CLK,
   input logic                RESET,
   calendar_date_gen_if.slave bus
);

   localparam logic [6:0] Y_MIN  = 7'(YEAR_MIN);
   localparam logic [6:0] Y_MAX  = 7'(YEAR_MAX);
   localparam logic       LEAP_B = (LEAP_EN != 0);

   date_t      cur, nxt;
   logic       u_last, d_last, u_en, d_en;
   logic       year_wrap, wrap_nxt;
   logic       edit_go;
   logic [4:0] ml_cur, ml_edit;

   always_ff @(posedge CLK) begin
      if (RESET) begin
         cur.year  <= 7'(RST_YEAR);
         cur.month <= 7'(RST_MONTH);
         cur.day   <= 7'(RST_DAY);
         cur.wday  <= 3'(RST_WDAY);
         u_last    <= 1'b0;
         d_last    <= 1'b0;
         u_en      <= 1'b0;
         d_en      <= 1'b0;
         year_wrap <= 1'b0;
      end else begin
         cur       <= nxt;
         u_last    <= bus.U;
         d_last    <= bus.D;
         u_en      <= bus.U & ~u_last;
         d_en      <= bus.D & ~d_last;
         year_wrap <= wrap_nxt;
      end
   end

   always_comb begin
      nxt      = cur;
      wrap_nxt = 1'b0;
      ml_cur   = month_len(cur.month, cur.year, LEAP_B);
      ml_edit  = ml_cur;
      edit_go  = (bus.OPTION == OPT_DATE_SET) && (u_en ^ d_en);

      // A tick wins over a same-cycle edit; the edit event is simply lost.
      if (bus.DAY_TICK) begin
         nxt.wday = (cur.wday == 3'd6) ? 3'd0 : cur.wday + 3'd1;
         if ({2'b00, ml_cur} > cur.day) begin
            nxt.day = cur.day + 7'd1;
         end else begin
            nxt.day = 7'd1;
            if (cur.month != 7'd12) begin
               nxt.month = cur.month + 7'd1;
            end else begin
               nxt.month = 7'd1;
               if (cur.year == Y_MAX) begin
                  nxt.year = Y_MIN;
                  wrap_nxt = 1'b1;
               end else begin
                  nxt.year = cur.year + 7'd1;
               end
            end
         end
      end else if (edit_go) begin
         case (bus.COUNT)
            FIELD_DAY: begin
               if (u_en) begin
                  nxt.day  = (cur.day >= {2'b00, ml_cur}) ? 7'd1 : cur.day + 7'd1;
                  nxt.wday = (cur.wday == 3'd6) ? 3'd0 : cur.wday + 3'd1;
               end else begin
                  nxt.day  = (cur.day <= 7'd1) ? {2'b00, ml_cur} : cur.day - 7'd1;
                  nxt.wday = (cur.wday == 3'd0) ? 3'd6 : cur.wday - 3'd1;
               end
            end
            FIELD_MONTH: begin
               if (u_en) nxt.month = (cur.month == 7'd12) ? 7'd1 : cur.month + 7'd1;
               else      nxt.month = (cur.month == 7'd1) ? 7'd12 : cur.month - 7'd1;
            end
            FIELD_YEAR: begin
               if (u_en) nxt.year = (cur.year >= Y_MAX) ? Y_MIN : cur.year + 7'd1;
               else      nxt.year = (cur.year <= Y_MIN) ? Y_MAX : cur.year - 7'd1;
            end
            FIELD_WDAY: begin
               if (u_en) nxt.wday = (cur.wday == 3'd6) ? 3'd0 : cur.wday + 3'd1;
               else      nxt.wday = (cur.wday == 3'd0) ? 3'd6 : cur.wday - 3'd1;
            end
            default: ;
         endcase
         // Month/year edits can shorten the month under the current day.
         ml_edit = month_len(nxt.month, nxt.year, LEAP_B);
         if (nxt.day > {2'b00, ml_edit}) nxt.day = {2'b00, ml_edit};
      end
   end

   logic [2:0][6:0] bin;
   logic [2:0][3:0] tens, ones;

   assign bin = {cur.year, cur.month, cur.day};

   for (genvar i = 0; i < 3; i++) begin : g_bcd
      cal_bcd_split u_split (.bin(bin[i]), .tens(tens[i]), .ones(ones[i]));
   end

   assign bus.y10       = tens[2];
   assign bus.y1        = ones[2];
   assign bus.m10       = tens[1];
   assign bus.m1        = ones[1];
   assign bus.d10       = tens[0];
   assign bus.d1        = ones[0];
   assign bus.WDAY      = cur.wday;
   assign bus.LEAP      = LEAP_B && (cur.year[1:0] == 2'b00);
   assign bus.YEAR_WRAP = year_wrap;

endmodule
